// File: rtl/m_gshare_predictor.sv
// m_gshare_predictor: gshare branch direction predictor with init sweep and speculative history
// Ports:
//   w_clock, w_rst_n             clock (rising edge), asynchronous active-low reset
//   w_ready                      high once every table entry has been initialised
//   w_lookup, w_ra               fetch-stage lookup valid and PC index bits
//   w_prediction                 predicted taken (MSB of the indexed counter)
//   w_pred_idx, w_pred_hist      hashed index and history snapshot for the pipeline
//   w_we, w_wa, w_token          resolve-stage counter update: index and actual outcome
//   w_mispredict, w_hist_restore history repair on a mispredicted branch
module m_gshare_predictor #(
    parameter int IDX_W    = 5,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 5,
    parameter int INIT_VAL = 1
) (
    input  logic              w_clock,
    input  logic              w_rst_n,
    output logic              w_ready,
    input  logic              w_lookup,
    input  logic [IDX_W-1:0]  w_ra,
    output logic              w_prediction,
    output logic [IDX_W-1:0]  w_pred_idx,
    output logic [HIST_W-1:0] w_pred_hist,
    input  logic              w_we,
    input  logic [IDX_W-1:0]  w_wa,
    input  logic              w_token,
    input  logic              w_mispredict,
    input  logic [HIST_W-1:0] w_hist_restore
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [HIST_W-1:0] ghr, ghr_nxt;
    logic [CTR_W-1:0] table_q [2**IDX_W];
    logic [CTR_W-1:0] cur, upd;
    logic run;
    assign run = state == RUN;
    assign w_ready = run;
    assign w_pred_hist = ghr;
    assign w_pred_idx = w_ra ^ IDX_W'(ghr);
    assign w_prediction = run ? table_q[w_pred_idx][CTR_W-1] : 1'b0;
    assign cur = table_q[w_wa];
    assign upd = w_token ? ((&cur) ? cur : cur + 1'b1) : ((|cur) ? cur - 1'b1 : cur);
    always_comb begin
        state_nxt = state;
        ghr_nxt = ghr;
        if (!run && &ptr)
            state_nxt = RUN;
        // A mispredict repair outranks the speculative shift of a same-cycle lookup;
        // the truncating casts give the left shift for any HIST_W, including 1.
        if (run)
            ghr_nxt = (w_we && w_mispredict) ? HIST_W'({w_hist_restore, w_token})
                    : w_lookup ? HIST_W'({ghr, w_prediction}) : ghr;
    end
    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state <= INIT;
            ptr <= '0;
            ghr <= '0;
        end else begin
            state <= state_nxt;
            ghr <= ghr_nxt;
            ptr <= run ? ptr : ptr + 1'b1;
        end
    end
    // Table storage has no reset: the sweep rewrites every entry after reset.
    always_ff @(posedge w_clock) begin
        if (!run)
            table_q[ptr] <= CTR_W'(INIT_VAL);
        else if (w_we)
            table_q[w_wa] <= upd;
    end
endmodule

// File: tb/tb_m_gshare_predictor.sv
// tb_m_gshare_predictor: directed vector and sequence checks for m_gshare_predictor
module tb_m_gshare_predictor;
    logic       w_clock = 1'b0;
    logic       w_rst_n = 1'b0;
    logic       w_ready;
    logic       w_lookup = 1'b0;
    logic [4:0] w_ra = '0;
    logic       w_prediction;
    logic [4:0] w_pred_idx;
    logic [4:0] w_pred_hist;
    logic       w_we = 1'b0;
    logic [4:0] w_wa = '0;
    logic       w_token = 1'b0;
    logic       w_mispredict = 1'b0;
    logic [4:0] w_hist_restore = '0;
    typedef struct {
        int lk, ra, we, wa, tk, mp, rs, ep, ei, eh;
    } vec_t;
    vec_t vt[21];
    int pass = 0;
    int total = 0;
    always #5 w_clock = ~w_clock;
    m_gshare_predictor dut (
        .w_clock(w_clock),
        .w_rst_n(w_rst_n),
        .w_ready(w_ready),
        .w_lookup(w_lookup),
        .w_ra(w_ra),
        .w_prediction(w_prediction),
        .w_pred_idx(w_pred_idx),
        .w_pred_hist(w_pred_hist),
        .w_we(w_we),
        .w_wa(w_wa),
        .w_token(w_token),
        .w_mispredict(w_mispredict),
        .w_hist_restore(w_hist_restore)
    );
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic drive(input int lk, input int ra, input int we, input int wa,
                         input int tk, input int mp, input int rs);
        w_lookup = 1'(lk);
        w_ra = 5'(ra);
        w_we = 1'(we);
        w_wa = 5'(wa);
        w_token = 1'(tk);
        w_mispredict = 1'(mp);
        w_hist_restore = 5'(rs);
    endtask
    task automatic sweep(input string nm);
        for (int i = 1; i <= 32; i++) begin
            @(posedge w_clock);
            #1;
            chk($sformatf("%s_ready_e%0d", nm, i), int'(w_ready), int'(i == 32));
            chk($sformatf("%s_pred_e%0d", nm, i), int'(w_prediction), 0);
            chk($sformatf("%s_hist_e%0d", nm, i), int'(w_pred_hist), 0);
        end
    endtask
    task automatic scan(input string nm);
        for (int i = 0; i < 32; i++) begin
            w_ra = 5'(i);
            #1;
            chk($sformatf("%s_pred_%0d", nm, i), int'(w_prediction), 0);
            chk($sformatf("%s_idx_%0d", nm, i), int'(w_pred_idx), i);
        end
    endtask
    initial begin
        vt[0]  = '{0, 7, 1, 7, 1, 0, 0, 0, 7, 0};
        vt[1]  = '{0, 7, 1, 7, 1, 0, 0, 1, 7, 0};
        vt[2]  = '{0, 7, 1, 7, 1, 0, 0, 1, 7, 0};
        vt[3]  = '{0, 7, 1, 7, 1, 0, 0, 1, 7, 0};
        vt[4]  = '{0, 7, 1, 7, 1, 0, 0, 1, 7, 0};
        vt[5]  = '{0, 7, 1, 7, 0, 0, 0, 1, 7, 0};
        vt[6]  = '{0, 7, 1, 7, 0, 0, 0, 1, 7, 0};
        vt[7]  = '{0, 7, 1, 7, 0, 0, 0, 0, 7, 0};
        vt[8]  = '{0, 7, 1, 7, 0, 0, 0, 0, 7, 0};
        vt[9]  = '{0, 7, 1, 7, 1, 0, 0, 0, 7, 0};
        vt[10] = '{0, 7, 0, 0, 0, 0, 0, 0, 7, 0};
        vt[11] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 1, 2, 1, 0, 0, 1, 0, 0};
        vt[13] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[15] = '{1, 0, 0, 0, 0, 0, 0, 1, 2, 2};
        vt[16] = '{1, 5, 0, 0, 0, 0, 0, 1, 0, 5};
        vt[17] = '{1, 10, 0, 0, 0, 0, 0, 0, 1, 11};
        vt[18] = '{1, 0, 1, 1, 0, 1, 3, 0, 22, 22};
        vt[19] = '{1, 15, 1, 9, 1, 0, 0, 0, 9, 6};
        vt[20] = '{0, 5, 0, 0, 0, 0, 0, 1, 9, 12};
        #2;
        chk("por_ready", int'(w_ready), 0);
        chk("por_hist", int'(w_pred_hist), 0);
        repeat (2) @(posedge w_clock);
        @(negedge w_clock);
        w_rst_n = 1'b1;
        sweep("sweep1");
        @(negedge w_clock);
        w_rst_n = 1'b0;
        @(negedge w_clock);
        w_rst_n = 1'b1;
        repeat (10) @(posedge w_clock);
        @(negedge w_clock);
        #1 w_rst_n = 1'b0;
        #1 chk("step10_rst_ready", int'(w_ready), 0);
        @(negedge w_clock);
        w_rst_n = 1'b1;
        sweep("sweep2");
        scan("scan2");
        for (int k = 0; k < 21; k++) begin
            @(negedge w_clock);
            drive(vt[k].lk, vt[k].ra, vt[k].we, vt[k].wa, vt[k].tk, vt[k].mp, vt[k].rs);
            #1;
            chk($sformatf("vec%0d_pred", k), int'(w_prediction), vt[k].ep);
            chk($sformatf("vec%0d_idx", k), int'(w_pred_idx), vt[k].ei);
            chk($sformatf("vec%0d_hist", k), int'(w_pred_hist), vt[k].eh);
        end
        @(negedge w_clock);
        drive(0, 5, 0, 0, 0, 0, 0);
        #1 chk("run_pre_rst_pred", int'(w_prediction), 1);
        #1 w_rst_n = 1'b0;
        #1;
        chk("run_rst_ready", int'(w_ready), 0);
        chk("run_rst_hist", int'(w_pred_hist), 0);
        chk("run_rst_idx", int'(w_pred_idx), 5);
        chk("run_rst_pred", int'(w_prediction), 0);
        @(negedge w_clock);
        w_rst_n = 1'b1;
        drive(1, 9, 1, 9, 1, 1, 31);
        sweep("sweep3");
        drive(0, 0, 0, 0, 0, 0, 0);
        scan("scan3");
        @(negedge w_clock);
        drive(0, 9, 1, 9, 1, 0, 0);
        @(posedge w_clock);
        #1 drive(0, 9, 0, 0, 0, 0, 0);
        #1 chk("post_sweep_e9_pred", int'(w_prediction), 1);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
